uart_tx: RTL
============

# uart_tx

Serial UART transmitter that consumes the per-bit `baud_tick` pulse from the team's baud generator. It accepts a parallel word over a valid/ready handshake and shifts it out on `tx` as one frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. Each bit lasts exactly one tick period. It sits between the host-side command logic and the UART pin.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `baud_tick`  in  1  single-cycle pulse, once per bit period, from the baud generator.
- `tx_data`  in  DATA_BITS  word to transmit; sampled only on accept.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  registered; high only in IDLE.
- `tx`  out  1  registered serial line; idle level is 1.
- `tx_busy`  out  1  high whenever state ≠ IDLE.
- `tx_done`  out  1  one-cycle pulse when the frame's final stop bit ends.

## Operation
- **Reset values:** state = IDLE, `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0, shift register = 0, counters = 0.
- **States:** IDLE, SYNC, START, DATA, PARITY, STOP.
- **IDLE:** `tx` = 1. `baud_tick` is ignored unless an accept occurs in the same cycle.
- **Accept:** the cycle where `tx_valid` && `tx_ready`.
  - `tx_data` is loaded into the shift register.
  - Parity is computed from the loaded word: even = XOR of the bits; odd = inverted XOR.
- **After accept:**
  - If `baud_tick` is also high that cycle, go to START.
  - Otherwise go to SYNC.
- **SYNC:** `tx` stays 1. The next `baud_tick` moves to START.
- **START:** `tx` = 0. On `baud_tick`, go to DATA and clear the bit counter.
- **DATA:** `tx` = shift register bit 0. On each `baud_tick`:
  - shift right by one and increment the bit counter;
  - after bit `DATA_BITS-1`, go to PARITY if `PARITY` ≠ 0, else to STOP.
- **PARITY:** `tx` = the computed parity bit. On `baud_tick`, go to STOP.
- **STOP:** `tx` = 1. The stop counter counts `STOP_BITS` ticks. On the final tick:
  - go to IDLE;
  - pulse `tx_done`.
- **No acceptance while busy:** `tx_valid` outside IDLE is ignored. `tx_data` may change freely after accept without affecting the frame.
- **Unused state encodings** recover to IDLE with `tx` = 1.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous), the frame is discarded, and no `tx_done` is produced.

## Timing
- **`tx` latency:** all `tx` changes appear on the clock edge after the state transition is decided, i.e. one cycle after the triggering `baud_tick` or accept.
- **`tx_ready`** falls on the edge after accept. It rises on the same edge on which the state returns to IDLE.
- **Start bit onset:**
  - Tick coincident with accept: start bit begins at cycle accept+1.
  - Otherwise: start bit begins one cycle after the first `baud_tick` following accept.
- **Bit length:** every bit (start, data, parity, stop) lasts exactly one tick-to-tick interval, i.e. CLOCK_FREQ/BAUD_RATE cycles.
- **Frame length:** 1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS` tick periods.
- **`tx_done`:** high for exactly the one cycle following the final stop tick, concurrent with `tx_ready` returning high.
- **Back-to-back frames:** `tx_valid` held high is accepted in the first IDLE cycle, which falls mid-period. The result is at most one bit period of extra idle-high between frames. There are no zero-length or shortened bits.
- **Tick rate:** `baud_tick` pulses are assumed spaced ≥ 2 cycles apart. A tick arriving while `rst` is high is ignored.

## Test plan
1. **Basic frame.** Setup: `DATA_BITS`=8, no parity, 1 stop, tick every 104 cycles. Stimulus: send 0xA5. Required: `tx` = 0,1,0,1,0,0,1,0,1,1, each level exactly 104 cycles; `tx_done` pulses once; `tx_ready` back to 1 after 10 periods.
2. **Parity.** Stimulus: send 0x07 with `PARITY`=2, then with `PARITY`=1. Required: parity bit = 1 (even), then 0 (odd). With `STOP_BITS`=2 the line stays high for 2 periods before `tx_done`.
3. **Tick coincident with accept.** Stimulus: `tx_valid` and `baud_tick` high in the same cycle. Required: `tx` = 0 at the next cycle; the start bit length is exactly one period.
4. **Valid while busy.** Stimulus: pulse `tx_valid` with 0x3C mid-frame. Required: ignored, `tx_ready` stays 0, and the current frame bits are unchanged. Then hold `tx_valid` with 0x3C across frame end. Required: accepted in the first IDLE cycle, and the next start bit begins after the following tick.
5. **Reset mid-frame.** Stimulus: assert `rst` during data bit 3. Required: `tx` = 1 and `tx_ready` = 1 immediately, no `tx_done`. After release, a fresh 0x55 frame transmits correctly.
6. **Minimum width.** Setup: `DATA_BITS`=5, no parity. Stimulus: send 0x1F. Required: frame of 7 periods, `tx` = 0,1,1,1,1,1,1.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: takes a word over valid/ready and shifts out start, data (LSB first),
// optional parity and 1-2 stop bits, one bit per baud_tick period.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // SYNC waits for the first tick after an accept so the start bit is never shortened.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 accept;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        done_d     = 1'b0;
        accept     = tx_valid && ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d  = tx_data;
                    parity_d = (PARITY == 2) ? (^tx_data) : ~(^tx_data);
                    state_d  = baud_tick ? S_START : S_SYNC;
                end
            end
            S_SYNC: begin
                if (baud_tick) state_d = S_START;
            end
            S_START: begin
                if (baud_tick) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PAR: begin
                if (baud_tick) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next state, so it lags the decision by one cycle.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_PAR:   tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != S_IDLE);

endmodule
